fir_mac_scheduler: RTL and testbench

- Time-multiplexed 17-tap low-pass FIR for the I and Q channels of the FM demodulator.
- Uses one shared 16x16 multiplier and one accumulator.
- Arbitrates between the two channel sample streams and sequences the tap loop through a FSM.
- Emits one rounded, saturated 16-bit result per accepted sample, tagged with its channel.

---
 rtl/fir_pkg.sv | 31 +++
 rtl/fir_mac_unit.sv | 47 ++++
 rtl/fir_mac_scheduler.sv | 156 +++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the time-multiplexed I/Q FIR: coefficient set,
// FSM state encoding and the rounding/saturation constants.
package fir_pkg;

  localparam int DATA_W = 16;
  localparam int TAPS   = 17;
  localparam int TAP_W  = $clog2(TAPS);
  localparam int FRAC_W = 16;

  // Half an LSB of the 16.0 result, expressed in accumulator (0.16-scaled) units.
  localparam int RND_BIAS = 1 << (FRAC_W - 1);
  localparam int SAT_MAX  = 32767;
  localparam int SAT_MIN  = -32768;

  typedef logic signed [DATA_W-1:0] coef_t;

  // Low-pass taps in 0.16 format, symmetric, DC gain 65535/65536.
  localparam coef_t COEF [TAPS] = '{
    16'sd166,  16'sd376,  16'sd964,  16'sd2062, 16'sd3636, 16'sd5468,
    16'sd7202, 16'sd8445, 16'sd8897, 16'sd8445, 16'sd7202, 16'sd5468,
    16'sd3636, 16'sd2062, 16'sd964,  16'sd376,  16'sd166
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// Registered 16x16 multiply feeding a single accumulator, plus the
// round-half-up and saturate stage that turns the accumulator into a 16.0 sample.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             mul_en,
  input  logic [WIDTH-1:0] coef,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] result
);

  logic signed [2*WIDTH-1:0] prod;
  logic                      prod_vld;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   rounded;
  logic signed [ACC_W-1:0]   shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= mul_en;
      if (mul_en) prod <= $signed(coef) * $signed(sample);
      // The product lands one cycle after issue, so the add trails the multiply.
      if (clear)         acc <= '0;
      else if (prod_vld) acc <= acc + ACC_W'(prod);
    end
  end

  assign rounded = acc + ACC_W'(RND_BIAS);
  assign shifted = rounded >>> FRAC_W;

  always_comb begin
    result = shifted[WIDTH-1:0];
    if (shifted > ACC_W'(SAT_MAX))      result = WIDTH'(SAT_MAX);
    else if (shifted < ACC_W'(SAT_MIN)) result = WIDTH'(SAT_MIN);
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Two-channel 17-tap FIR sharing one MAC: holding registers, round-robin
// arbitration, per-channel delay lines and the IDLE/MAC/DRAIN/OUT sequencer.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int    WIDTH          = DATA_W,
  parameter int    ACC_W          = 40,
  parameter coef_t COEF_SET [TAPS] = COEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data_i,
  input  logic             i_valid_i,
  output logic             i_ready_o,
  input  logic [WIDTH-1:0] q_data_i,
  input  logic             q_valid_i,
  output logic             q_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             ch_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  state_t           state, state_nx;
  logic             full_i, full_q;
  logic [WIDTH-1:0] hold_i, hold_q;
  logic [WIDTH-1:0] line_i [TAPS];
  logic [WIDTH-1:0] line_q [TAPS];
  logic             ptr, sel_ch;
  logic [TAP_W-1:0] k;
  logic             drain_cnt;
  logic             grant, grant_ch, mul_en, clear;
  logic [WIDTH-1:0] tap_sample, result;

  // Handshake: a sample transfers on any edge where valid and ready are both
  // high; ready is simply "holding register empty" and is cleared by the grant.
  assign i_ready_o = ~full_i;
  assign q_ready_o = ~full_q;
  assign busy_o    = (state != IDLE);
  assign state_o   = state;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_ch = ptr;
    mul_en   = 1'b0;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (full_i || full_q) begin
          grant    = 1'b1;
          grant_ch = (full_i && full_q) ? ptr : full_q;
          clear    = 1'b1;
          state_nx = MAC;
        end
      end
      MAC: begin
        mul_en = 1'b1;
        if (k == TAP_W'(TAPS - 1)) state_nx = DRAIN;
      end
      DRAIN:   if (drain_cnt) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      drain_cnt <= 1'b0;
      ptr       <= 1'b0;
      sel_ch    <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        sel_ch    <= grant_ch;
        ptr       <= ~grant_ch;
        k         <= '0;
        drain_cnt <= 1'b0;
      end
      if (state == MAC)   k         <= k + 1'b1;
      if (state == DRAIN) drain_cnt <= 1'b1;
    end
  end

  // A grant frees the register in the same edge, so a new arrival can only be
  // taken once ready has been seen high again.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_i <= 1'b0;
      full_q <= 1'b0;
      hold_i <= '0;
      hold_q <= '0;
    end else begin
      if (grant && !grant_ch) full_i <= 1'b0;
      else if (i_valid_i && !full_i) begin
        full_i <= 1'b1;
        hold_i <= i_data_i;
      end
      if (grant && grant_ch) full_q <= 1'b0;
      else if (q_valid_i && !full_q) begin
        full_q <= 1'b1;
        hold_q <= q_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) begin
        line_i[t] <= '0;
        line_q[t] <= '0;
      end
    end else if (grant) begin
      if (!grant_ch) begin
        line_i[0] <= hold_i;
        for (int t = 1; t < TAPS; t++) line_i[t] <= line_i[t-1];
      end else begin
        line_q[0] <= hold_q;
        for (int t = 1; t < TAPS; t++) line_q[t] <= line_q[t-1];
      end
    end
  end

  assign tap_sample = sel_ch ? line_q[k] : line_i[k];

  fir_mac_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .mul_en (mul_en),
    .coef   (COEF_SET[k]),
    .sample (tap_sample),
    .result (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      ch_o    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= (state == OUT);
      if (state == OUT) begin
        data_o <= result;
        ch_o   <= sel_ch;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: impulse, step, arbitration, holding
// register, reset abort and (on a second instance with large taps) saturation.
module tb_fir_mac_scheduler;
  import fir_pkg::*;

  localparam coef_t SAT_COEF [TAPS] = '{default: 16'sd32767};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        [15:0] i_data = '0, q_data = '0;
  logic               i_valid = 1'b0, q_valid = 1'b0;
  logic               sat_sel = 1'b0;

  logic        [15:0] m_data, s_data;
  logic               m_ch, m_valid, m_busy, m_i_ready, m_q_ready;
  logic               s_ch, s_valid, s_busy, s_i_ready, s_q_ready;
  logic        [1:0]  m_state, s_state;
  logic               m_i_valid, m_q_valid, s_i_valid, s_q_valid;
  logic               cur_i_ready, cur_q_ready;

  assign m_i_valid   = i_valid & ~sat_sel;
  assign m_q_valid   = q_valid & ~sat_sel;
  assign s_i_valid   = i_valid & sat_sel;
  assign s_q_valid   = q_valid & sat_sel;
  assign cur_i_ready = sat_sel ? s_i_ready : m_i_ready;
  assign cur_q_ready = sat_sel ? s_q_ready : m_q_ready;

  fir_mac_scheduler dut (
    .clk (clk), .rst (rst),
    .i_data_i (i_data), .i_valid_i (m_i_valid), .i_ready_o (m_i_ready),
    .q_data_i (q_data), .q_valid_i (m_q_valid), .q_ready_o (m_q_ready),
    .data_o (m_data), .ch_o (m_ch), .valid_o (m_valid), .busy_o (m_busy),
    .state_o (m_state)
  );

  fir_mac_scheduler #(.COEF_SET (SAT_COEF)) dut_sat (
    .clk (clk), .rst (rst),
    .i_data_i (i_data), .i_valid_i (s_i_valid), .i_ready_o (s_i_ready),
    .q_data_i (q_data), .q_valid_i (s_q_valid), .q_ready_o (s_q_ready),
    .data_o (s_data), .ch_o (s_ch), .valid_o (s_valid), .busy_o (s_busy),
    .state_o (s_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [16:0] exp_q[$];
  int          lat_q[$];
  logic [16:0] exp_s_q[$];
  int          tx_cyc;

  int imp_tab [17] = '{83, 188, 482, 1031, 1818, 2734, 3601, 4222, 4448,
                       4222, 3601, 2734, 1818, 1031, 482, 188, 83};
  int step_tab [17] = '{42, 136, 377, 892, 1801, 3168, 4969, 7080, 9304,
                        11415, 13216, 14583, 15492, 16007, 16248, 16342, 16384};

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [16:0] m_e;
  int          m_l;
  logic        m_prev_valid = 1'b0;
  always @(negedge clk) begin
    if (m_valid) begin
      check("strobe_width", m_prev_valid, 0);
      if (exp_q.size() == 0) check("spurious_valid", m_valid, 0);
      else begin
        m_e = exp_q.pop_front();
        m_l = lat_q.pop_front();
        check("data", $signed(m_data), $signed(m_e[15:0]));
        check("ch", m_ch, m_e[16]);
        if (m_l >= 0) check("latency", cyc, m_l);
      end
    end
    m_prev_valid = m_valid;
  end

  logic [16:0] s_e;
  always @(negedge clk) begin
    if (s_valid) begin
      if (exp_s_q.size() == 0) check("sat_spurious_valid", s_valid, 0);
      else begin
        s_e = exp_s_q.pop_front();
        check("sat_data", $signed(s_data), $signed(s_e[15:0]));
        check("sat_ch", s_ch, s_e[16]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic ch, input int val, input int lat);
    exp_q.push_back({ch, 16'(val)});
    lat_q.push_back(lat);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with
  // valid still asserted so a caller can stream the next sample.
  task automatic send(input logic ch, input logic [15:0] d);
    int guard = 0;
    if (!ch) begin i_data = d; i_valid = 1'b1; end
    else     begin q_data = d; q_valid = 1'b1; end
    while (!(ch ? cur_q_ready : cur_i_ready) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("ready_timeout", guard, 0);
    @(posedge clk);
    #1 tx_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0;
    q_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() + exp_s_q.size()) != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("drain_timeout", exp_q.size() + exp_s_q.size(), 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    exp_q.delete();
    lat_q.delete();
    exp_s_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check("rst_data", m_data, 0);
    check("rst_ch", m_ch, 0);
    check("rst_valid", m_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_i_ready", m_i_ready, 1);
    check("rst_q_ready", m_q_ready, 1);
    check("rst_state", m_state, 0);
    check("rst_sat_valid", s_valid, 0);
    rst = 1'b0;
  endtask

  task automatic run_impulse(input logic [15:0] amp, input int n, input int sgn);
    for (int t = 0; t < n; t++) begin
      send(1'b0, (t == 0) ? amp : 16'd0);
      idle_inputs();
      push_exp(1'b0, sgn * imp_tab[t], tx_cyc + 21);
      wait_drain();
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int txq;
    repeat (2) @(negedge clk);
    do_reset();

    // Positive impulse on I: outputs are floor(coef/2).
    run_impulse(16'd32767, 17, 1);

    // Step of 16384 on I.
    do_reset();
    for (int t = 0; t < 17; t++) begin
      send(1'b0, 16'd16384);
      idle_inputs();
      push_exp(1'b0, step_tab[t], tx_cyc + 21);
      wait_drain();
    end

    // Negative full-scale impulse, taps 0..8.
    do_reset();
    run_impulse(16'h8000, 9, -1);

    // Both channels arrive together: I first, Q waits for I to finish.
    do_reset();
    i_data = 16'd1000; q_data = 16'd2000;
    i_valid = 1'b1;    q_valid = 1'b1;
    @(posedge clk);
    #1 tx_cyc = cyc;
    @(negedge clk);
    idle_inputs();
    push_exp(1'b0, 3, tx_cyc + 21);
    push_exp(1'b1, 5, tx_cyc + 42);
    check("sim_i_ready_held", m_i_ready, 0);
    check("sim_q_ready_held", m_q_ready, 0);
    @(negedge clk);
    check("sim_i_ready_granted", m_i_ready, 1);
    check("sim_q_ready_wait", m_q_ready, 0);
    repeat (20) @(negedge clk);
    check("sim_q_ready_late", m_q_ready, 0);
    @(negedge clk);
    check("sim_q_ready_granted", m_q_ready, 1);
    wait_drain();

    // I held valid with three samples while Q computes.
    do_reset();
    send(1'b1, 16'd20000);
    q_valid = 1'b0;
    txq = tx_cyc;
    push_exp(1'b1, 51, txq + 21);
    repeat (3) @(negedge clk);
    send(1'b0, 16'd8000);
    push_exp(1'b0, 20, txq + 42);
    i_data = 16'd16000;
    check("hold_i_ready_low", m_i_ready, 0);
    repeat (5) @(negedge clk);
    check("hold_i_ready_still_low", m_i_ready, 0);
    send(1'b0, 16'd16000);
    push_exp(1'b0, 86, txq + 63);
    send(1'b0, 16'd24000);
    push_exp(1'b0, 270, txq + 84);
    idle_inputs();
    wait_drain();

    // Reset during a Q computation aborts it; lines come back cleared.
    send(1'b1, 16'd30000);
    idle_inputs();
    repeat (8) @(negedge clk);
    check("abort_busy", m_busy, 1);
    do_reset();
    repeat (30) @(negedge clk);
    run_impulse(16'd32767, 17, 1);

    // Saturation on the large-coefficient instance.
    do_reset();
    sat_sel = 1'b1;
    for (int t = 0; t < 17; t++) begin
      send(1'b0, 16'd32767);
      idle_inputs();
      exp_s_q.push_back({1'b0, (t == 0) ? 16'd16383 : (t == 1) ? 16'd32766 : 16'd32767});
      wait_drain();
    end
    do_reset();
    for (int t = 0; t < 3; t++) begin
      send(1'b0, 16'h8000);
      idle_inputs();
      exp_s_q.push_back({1'b0, (t == 0) ? 16'hC001 : (t == 1) ? 16'h8001 : 16'h8000});
      wait_drain();
    end
    sat_sel = 1'b0;

    repeat (5) @(negedge clk);
    check("pending_outputs", exp_q.size() + exp_s_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
